// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: up to 16 requests in, one registered one-hot grant out.
// Request-to-grant and ack-to-release are 1 cycle each; a grant is held until ack or withdraw.
module onehot_rr_arbiter #(
  parameter int N_REQ = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [N_REQ-1:0]   r_grant;
  logic               r_grant_valid;
  logic               r_busy;

  logic [PTR_W-1:0]   w_win;
  logic               w_found;

  // First requester at or after the pointer, scanning with natural wrap.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      logic [PTR_W-1:0] idx;
      idx = r_ptr + PTR_W'(i);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gidx        <= w_win;
            r_grant       <= N_REQ'(1) << w_win;
            r_grant_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= GRANT;
          end
        end
        GRANT: begin
          // Ack wins over a simultaneous withdraw, so the pointer still advances.
          if (ack || !req[r_gidx]) begin
            if (ack) begin
              r_ptr <= r_gidx + PTR_W'(1);
            end
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_onehot_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        ack;
  logic [15:0] grant;
  logic        grant_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_rr_arbiter #(.N_REQ(16), .PTR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: whether a grant is held, to whom, and the priority index.
  bit m_started = 1'b0;
  bit m_granting = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (reset) begin
      m_granting = 1'b0;
      m_idx      = 0;
      m_ptr      = 0;
    end else if (!m_granting) begin
      if (req != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (req[(m_ptr + k) % 16]) begin
            m_idx      = (m_ptr + k) % 16;
            m_granting = 1'b1;
            break;
          end
        end
      end
    end else if (ack) begin
      m_ptr      = (m_idx + 1) % 16;
      m_granting = 1'b0;
    end else if (!req[m_idx]) begin
      m_granting = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      logic [15:0] exp_grant;
      exp_grant = m_granting ? (16'h1 << m_idx) : 16'h0;
      chk("model_grant", 32'(grant), 32'(exp_grant));
      chk("model_grant_valid", 32'(grant_valid), 32'(m_granting));
      chk("model_busy", 32'(busy), 32'(m_granting));
      chk("model_ptr", 32'(dut.r_ptr), 32'(m_ptr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req   = 16'h0;
    ack   = 1'b0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] rot_exp [4];
    rot_exp[0] = 16'h0001;
    rot_exp[1] = 16'h8000;
    rot_exp[2] = 16'h0001;
    rot_exp[3] = 16'h8000;

    // Reset and first grant
    do_reset(2);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_gv", 32'(grant_valid), 32'h0);
    req = 16'h0002;
    step();
    chk("first_grant", 32'(grant), 32'h0002);
    chk("first_gv", 32'(grant_valid), 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 16'h0;

    // Fair rotation from pointer 0
    do_reset(2);
    req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rot_grant", 32'(grant), 32'(rot_exp[k]));
      ack = 1'b1;
      step();
      chk("rot_gap", 32'(grant), 32'h0);
      ack = 1'b0;
    end
    req = 16'h0;

    // Pointer wrap
    req = 16'h2000;
    step();
    chk("wrap_g13", 32'(grant), 32'h2000);
    ack = 1'b1;
    step();
    chk("wrap_ptr14", 32'(dut.r_ptr), 32'd14);
    ack = 1'b0;
    req = 16'h4005;
    step();
    chk("wrap_g14", 32'(grant), 32'h4000);
    ack = 1'b1;
    step();
    chk("wrap_ptr15", 32'(dut.r_ptr), 32'd15);
    ack = 1'b0;
    req = 16'h0005;
    step();
    chk("wrap_g0", 32'(grant), 32'h0001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 16'h0;

    // Withdraw
    do_reset(2);
    req = 16'h0010;
    step();
    chk("wd_grant", 32'(grant), 32'h0010);
    req = 16'h0;
    step();
    chk("wd_release", 32'(grant), 32'h0);
    chk("wd_ptr", 32'(dut.r_ptr), 32'd0);
    req = 16'h0011;
    step();
    chk("wd_regrant", 32'(grant), 32'h0001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 16'h0;

    // Ack in IDLE is ignored; ack plus withdraw counts as ack
    ack = 1'b1;
    step();
    chk("idle_ack_grant", 32'(grant), 32'h0);
    chk("idle_ack_ptr", 32'(dut.r_ptr), 32'd1);
    ack = 1'b0;
    req = 16'h0004;
    step();
    chk("aw_grant", 32'(grant), 32'h0004);
    ack = 1'b1;
    req = 16'h0;
    step();
    chk("aw_release", 32'(grant), 32'h0);
    chk("aw_ptr", 32'(dut.r_ptr), 32'd3);
    ack = 1'b0;

    // Reset mid-grant
    req = 16'h0080;
    step();
    chk("mid_grant", 32'(grant), 32'h0080);
    reset = 1'b1;
    step();
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ptr", 32'(dut.r_ptr), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_regrant", 32'(grant), 32'h0080);
    req = 16'h0;
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: req = 16'h0;
        1: req = 16'(1) << $urandom_range(0, 15);
        2: req = 16'($urandom) & 16'($urandom);
        default: req = 16'($urandom);
      endcase
      step();
    end

    reset = 1'b0;
    req   = 16'h0;
    ack   = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that turns up to 16 independent request lines into a single registered one-hot grant vector. It sits directly upstream of the 16-to-4 case encoder. `grant` drives `encoder_in` and `grant_valid` drives `enable`, so the encoder always sees either a clean one-hot word or is disabled. Fairness is held by a rotating priority pointer. A granted requester keeps the grant until it acknowledges or withdraws its request.

## Interface
- `N_REQ`, 16, number of request lines; fixed at 16 to match the encoder width.
- `PTR_W`, 4, width of the priority pointer and the internal grant index; log2(`N_REQ`).

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  16  request vector; bit i high means requester i wants service.
- `ack`  input  1  the granted requester has finished; sampled only in GRANT.
- `grant`  output  16  registered one-hot grant; all zeros when not granting.
- `grant_valid`  output  1  high exactly when `grant` is non-zero; feeds the encoder enable.
- `busy`  output  1  high while in GRANT; equals `grant_valid`.

## Operation
- The design is one clock domain with a synchronous, active-high reset.
- Reset values: state = IDLE, `ptr` = 0, `gidx` = 0, `grant` = 16'h0000, `grant_valid` = 0, `busy` = 0.
- Internal state:
  - `ptr` (`PTR_W` bits) is the highest-priority index.
  - `gidx` (`PTR_W` bits) is the index of the current grant.
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise select winner w = the first i scanning `ptr`, `ptr`+1, … , 15, 0, … , `ptr`-1 with `req[i]` = 1.
  - At the next edge: `gidx` <= w, `grant` <= (1 << w), `grant_valid` <= 1, state <= GRANT.
  - `ack` is ignored in IDLE.
- GRANT: `grant` is held constant. Exit conditions, checked in priority order:
  1. `ack` = 1: release and advance the pointer. `ptr` <= `gidx` + 1 mod 16, wrapping from 15 to 0.
  2. `req[gidx]` = 0 with `ack` = 0 (withdraw): release; `ptr` is unchanged.
  3. Otherwise stay in GRANT.
- Release means: at the next edge `grant` <= 0, `grant_valid` <= 0, state <= IDLE.
- Changes to other `req` bits during GRANT have no effect until the next arbitration.
- `ptr` arithmetic is modulo 16, using natural 4-bit wrap.
- Invariant: `grant` always has popcount 0 or 1, and `grant_valid` == (`grant` != 0).

## Timing
- Request-to-grant latency is 1 cycle. `req` is sampled at edge k in IDLE and `grant` is valid after edge k.
- Ack-to-release latency is 1 cycle. `ack` is sampled at edge k and `grant` is 0 after edge k.
- There is a mandatory single idle cycle between consecutive grants, so maximum throughput is one grant per 2 cycles. Minimum grant duration is 1 cycle, which happens when `ack` is high on the first GRANT cycle.
- `ack` and withdraw asserted in the same cycle are treated as `ack`, so the pointer advances.
- Reset asserted in any state, including mid-GRANT, returns every register to its reset value at that edge. Reset has priority over `ack`, `req` and all state transitions.
- The `req` scan is combinational within one cycle; all outputs are registered with no combinational path from inputs to outputs.
- End-to-end with the downstream encoder: `binary_out` equals `gidx` one cycle after the request is sampled, or 0 while `grant_valid` = 0.

## Test plan
- **Reset and first grant:** hold `reset` for 2 cycles, then release and drive `req` = 16'h0002. Required:
  - After reset: `grant` = 0000, `grant_valid` = 0.
  - One edge later: `grant` = 0002 and `grant_valid` = 1. Encoder `binary_out` = 1.
- **Fair rotation:** hold `req` = 16'h8001 and pulse `ack` on every GRANT cycle. Required:
  - Grants alternate 0001, 8000, 0001, 8000.
  - Each grant is separated by exactly one cycle with `grant` = 0.
- **Pointer wrap:**
  - `req` = 16'h2000, then ack. Required: `ptr` = 14.
  - Then `req` = 16'h4005. Required: grant 4000, then ack gives `ptr` = 15.
  - Then `req` = 16'h0005. Required: grant 0001 (wrap past 15).
- **Withdraw:** from `ptr` = 0, drive `req` = 16'h0010. Required: grant 0010.
  - Then drive `req` = 0 with `ack` = 0. Required: `grant` = 0 next cycle and `ptr` stays 0.
  - Then drive `req` = 16'h0011. Required: grant 0001.
- **Ack/withdraw edge cases:**
  - Pulse `ack` while in IDLE with `req` = 0. Required: no state change.
  - While holding grant 0004, drive `ack` = 1 and drop `req[2]` in the same cycle. Required: release and `ptr` = 3.
- **Reset mid-operation:** while grant 0080 is held, assert `reset` for 1 cycle with `req` = 16'h0080 kept high. Required:
  - `grant` = 0000 and `ptr` = 0 after that edge.
  - Re-grant 0080 one cycle after reset deasserts.
